// File: rtl/regfile_writeback_queue.sv
// Write-back queue: collects up to two register-write results per cycle
// (memory load first, then ALU) into an in-order FIFO and retires one write
// per cycle onto the register file's single registered write port. Also
// exposes a mask of destinations whose writes have not yet committed.
module regfile_writeback_queue #(
    parameter int DEPTH   = 4,
    parameter bit DROP_ZR = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         alu_valid,
    input  logic [4:0]                   alu_rd,
    input  logic [63:0]                  alu_data,
    output logic                         alu_ready,
    input  logic                         mem_valid,
    input  logic [4:0]                   mem_rd,
    input  logic [63:0]                  mem_data,
    output logic                         mem_ready,
    output logic [4:0]                   Write_register,
    output logic [63:0]                  Write_data,
    output logic                         RegWrite,
    output logic [31:0]                  pending_mask,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Entry storage; not reset, liveness comes from head/count.
    logic [4:0]  rd_mem   [DEPTH];
    logic [63:0] data_mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       write_register_q, write_register_d;
    logic [63:0]      write_data_q, write_data_d;

    logic [CNT_W-1:0] free_slots;
    logic             mem_push, alu_push;
    logic             mem_store, alu_store;
    logic             pop;
    logic [PTR_W-1:0] alu_slot;

    logic [31:0]      entry_mask [DEPTH];

    // Readiness looks only at start-of-cycle occupancy; a same-cycle pop is
    // deliberately not credited so there is no input-to-ready path.
    assign free_slots = CNT_W'(DEPTH) - count_q;
    assign mem_ready  = !reset && (free_slots >= CNT_W'(1));
    assign alu_ready  = !reset && (free_slots >= CNT_W'(2));

    assign mem_push  = mem_valid && mem_ready;
    assign alu_push  = alu_valid && alu_ready;
    // A push to XZR is a completed transfer that occupies no slot.
    assign mem_store = mem_push && !(DROP_ZR && (mem_rd == 5'd31));
    assign alu_store = alu_push && !(DROP_ZR && (alu_rd == 5'd31));
    assign pop       = (count_q != '0);

    // The load is the older instruction, so it takes the first free slot.
    assign alu_slot  = mem_store ? tail_q + PTR_W'(1) : tail_q;

    // Next-state for pointers, occupancy and the registered write port.
    always_comb begin
        head_d           = head_q;
        tail_d           = tail_q + PTR_W'(mem_store) + PTR_W'(alu_store);
        count_d          = count_q + CNT_W'(mem_store) + CNT_W'(alu_store)
                           - CNT_W'(pop);
        reg_write_d      = 1'b0;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        if (pop) begin
            head_d           = head_q + PTR_W'(1);
            reg_write_d      = 1'b1;
            write_register_d = rd_mem[head_q];
            write_data_d     = data_mem[head_q];
        end
    end

    // State registers; reset discards queued entries and idles the port.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
        end
    end

    // Entry storage writes; both sources may land in the same cycle.
    always_ff @(posedge clock) begin
        if (mem_store) begin
            rd_mem[tail_q]   <= mem_rd;
            data_mem[tail_q] <= mem_data;
        end
        if (alu_store) begin
            rd_mem[alu_slot]   <= alu_rd;
            data_mem[alu_slot] <= alu_data;
        end
    end

    // Per-entry contribution to the pending mask: live when its distance
    // from head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            logic [PTR_W-1:0] offset;
            logic             live;
            assign offset         = PTR_W'(gi) - head_q;
            assign live           = CNT_W'(offset) < count_q;
            assign entry_mask[gi] = live ? (32'd1 << rd_mem[gi]) : 32'd0;
        end
    endgenerate

    // Pending mask: queued destinations plus the one on the write port.
    always_comb begin
        pending_mask = reg_write_q ? (32'd1 << write_register_q) : 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_mask = pending_mask | entry_mask[i];
        end
    end

    assign RegWrite       = reg_write_q;
    assign Write_register = write_register_q;
    assign Write_data     = write_data_q;
    assign count          = count_q;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue (DEPTH=4, DROP_ZR=1).
module tb_regfile_writeback_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [63:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic [4:0]  Write_register;
    logic [63:0] Write_data;
    logic        RegWrite;
    logic [31:0] pending_mask;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_t;

    always #5 clock = ~clock;

    regfile_writeback_queue #(.DEPTH(4), .DROP_ZR(1'b1)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .Write_register(Write_register), .Write_data(Write_data), .RegWrite(RegWrite),
        .pending_mask(pending_mask), .count(count)
    );

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %0b want 0", RegWrite); end
        n_cmp++; if (Write_register !== 5'd0) begin n_err++; $display("FAIL reset_wreg: got %0d want 0", Write_register); end
        n_cmp++; if (Write_data !== 64'd0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", Write_data); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL reset_mask: got %h want 0", pending_mask); end
        n_cmp++; if ({mem_ready, alu_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", {mem_ready, alu_ready}); end
        reset = 1'b0;
        #1;
        n_cmp++; if ({mem_ready, alu_ready} !== 2'b11) begin n_err++; $display("FAIL post_reset_ready: got %b want 11", {mem_ready, alu_ready}); end
        tick();
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL post_reset_regwrite: got %0b want 0", RegWrite); end
    endtask

    task automatic test_single_alu;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        tick();
        idle_inputs();
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count1: got %0d want 1", count); end
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL single_early_write: got %0b want 0", RegWrite); end
        n_cmp++; if (pending_mask !== 32'h20) begin n_err++; $display("FAIL single_mask_q: got %h want 00000020", pending_mask); end
        tick();
        n_cmp++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd5, 64'h1234})
            begin n_err++; $display("FAIL single_write: got we=%0b rd=%0d data=%h want we=1 rd=5 data=1234", RegWrite, Write_register, Write_data); end
        n_cmp++; if (pending_mask !== 32'h20) begin n_err++; $display("FAIL single_mask_out: got %h want 00000020", pending_mask); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count0: got %0d want 0", count); end
        tick();
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL single_idle: got %0b want 0", RegWrite); end
        n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL single_mask_clear: got %h want 0", pending_mask); end
        n_cmp++; if ({Write_register, Write_data} !== {5'd5, 64'h1234})
            begin n_err++; $display("FAIL single_hold: got rd=%0d data=%h want rd=5 data=1234", Write_register, Write_data); end
    endtask

    task automatic test_dual_order;
        mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 64'hAA;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'hBB;
        tick();
        idle_inputs();
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL dual_count: got %0d want 2", count); end
        n_cmp++; if (pending_mask !== 32'h6) begin n_err++; $display("FAIL dual_mask: got %h want 00000006", pending_mask); end
        tick();
        n_cmp++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd1, 64'hAA})
            begin n_err++; $display("FAIL dual_first: got we=%0b rd=%0d data=%h want we=1 rd=1 data=aa", RegWrite, Write_register, Write_data); end
        tick();
        n_cmp++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd2, 64'hBB})
            begin n_err++; $display("FAIL dual_second: got we=%0b rd=%0d data=%h want we=1 rd=2 data=bb", RegWrite, Write_register, Write_data); end
        n_cmp++; if (pending_mask !== 32'h4) begin n_err++; $display("FAIL dual_mask_tail: got %h want 00000004", pending_mask); end
        tick();
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL dual_idle: got %0b want 0", RegWrite); end
    endtask

    // Both sources valid every cycle for 10 cycles. With one pop per cycle
    // the queue settles at 3 entries, where only the load source is ready.
    task automatic test_backpressure;
        wb_t sb[$];
        wb_t o;
        logic ov;
        logic m_acc, a_acc;
        int   seq = 0;
        int   accepted = 0;
        int   max_cnt = 0;
        ov = 1'b0;
        o  = '0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            logic drive;
            wb_t  m_e, a_e;
            drive     = (cyc < 10);
            m_e.rd    = 5'(seq % 31);
            m_e.data  = 64'h1000 + 64'(seq);
            a_e.rd    = 5'((seq + 1) % 31);
            a_e.data  = 64'h2000 + 64'(seq + 1);
            mem_valid = drive; mem_rd = m_e.rd; mem_data = m_e.data;
            alu_valid = drive; alu_rd = a_e.rd; alu_data = a_e.data;
            #1;
            n_cmp++; if (int'(count) !== sb.size()) begin n_err++; $display("FAIL bp_count c%0d: got %0d want %0d", cyc, count, sb.size()); end
            n_cmp++; if (mem_ready !== (sb.size() <= 3)) begin n_err++; $display("FAIL bp_mem_ready c%0d: got %0b want %0b", cyc, mem_ready, sb.size() <= 3); end
            n_cmp++; if (alu_ready !== (sb.size() <= 2)) begin n_err++; $display("FAIL bp_alu_ready c%0d: got %0b want %0b", cyc, alu_ready, sb.size() <= 2); end
            if (sb.size() > max_cnt) max_cnt = sb.size();
            m_acc = drive && (sb.size() <= 3);
            a_acc = drive && (sb.size() <= 2);
            tick();
            if (sb.size() > 0) begin ov = 1'b1; o = sb.pop_front(); end
            else ov = 1'b0;
            if (m_acc) begin sb.push_back(m_e); accepted++; end
            if (a_acc) begin sb.push_back(a_e); accepted++; end
            seq += 2;
            n_cmp++; if (RegWrite !== ov) begin n_err++; $display("FAIL bp_regwrite c%0d: got %0b want %0b", cyc, RegWrite, ov); end
            if (ov) begin
                n_cmp++; if ({Write_register, Write_data} !== {o.rd, o.data})
                    begin n_err++; $display("FAIL bp_write c%0d: got rd=%0d data=%h want rd=%0d data=%h", cyc, Write_register, Write_data, o.rd, o.data); end
            end
        end
        idle_inputs();
        // Hand count: 2 + 2 accepted in the first two cycles, then 1 per cycle.
        n_cmp++; if (accepted !== 12) begin n_err++; $display("FAIL bp_accepted: got %0d want 12", accepted); end
        n_cmp++; if (max_cnt !== 3) begin n_err++; $display("FAIL bp_max_count: got %0d want 3", max_cnt); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL bp_drained: got %0d want 0", count); end
    endtask

    task automatic test_waw;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'd1;
        tick();
        alu_data = 64'd2;
        tick();
        idle_inputs();
        n_cmp++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd7, 64'd1})
            begin n_err++; $display("FAIL waw_first: got we=%0b rd=%0d data=%0d want we=1 rd=7 data=1", RegWrite, Write_register, Write_data); end
        n_cmp++; if (pending_mask !== 32'h80) begin n_err++; $display("FAIL waw_mask1: got %h want 00000080", pending_mask); end
        tick();
        n_cmp++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd7, 64'd2})
            begin n_err++; $display("FAIL waw_second: got we=%0b rd=%0d data=%0d want we=1 rd=7 data=2", RegWrite, Write_register, Write_data); end
        n_cmp++; if (pending_mask !== 32'h80) begin n_err++; $display("FAIL waw_mask2: got %h want 00000080", pending_mask); end
        tick();
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL waw_idle: got %0b want 0", RegWrite); end
        n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL waw_mask_clear: got %h want 0", pending_mask); end
    endtask

    task automatic test_xzr;
        alu_valid = 1'b1; alu_rd = 5'd31; alu_data = 64'hFFFF;
        #1;
        n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL xzr_ready: got %0b want 1", alu_ready); end
        tick();
        idle_inputs();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL xzr_count: got %0d want 0", count); end
        n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL xzr_mask: got %h want 0", pending_mask); end
        tick();
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL xzr_regwrite: got %0b want 0", RegWrite); end
        n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL xzr_mask_late: got %h want 0", pending_mask); end
    endtask

    task automatic test_reset_mid_drain;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 64'hA0;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 64'hA1;
        tick();
        mem_rd = 5'd12; mem_data = 64'hA2;
        alu_rd = 5'd13; alu_data = 64'hA3;
        tick();
        idle_inputs();
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL rst_fill_count: got %0d want 3", count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL rst_regwrite: got %0b want 0", RegWrite); end
        n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL rst_mask: got %h want 0", pending_mask); end
        n_cmp++; if ({Write_register, Write_data} !== {5'd0, 64'd0})
            begin n_err++; $display("FAIL rst_port: got rd=%0d data=%h want rd=0 data=0", Write_register, Write_data); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL rst_stale c%0d: got %0b want 0", i, RegWrite); end
        end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count_late: got %0d want 0", count); end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_dual_order();
        test_backpressure();
        test_waw();
        test_xzr();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
